fadd2_seq: RTL and testbench

Sequential ripple adder that sums two WIDTH-bit operands plus carry-in two bits per clock, using one registered 2-bit full-add slice with the carry held in a flop between slices. It is the addition counterpart of the library's 2-bit borrow-chain subtractor cell. It sits in the arithmetic cell group as an area-minimal alternative to a WIDTH-bit carry chain, for datapaths that tolerate multi-cycle latency behind a start/done handshake.

---
 rtl/fadd2_seq_pkg.sv | 36 +++
 rtl/fadd2_slice.sv | 31 +++
 rtl/fadd2_seq.sv | 147 ++++++++++++++
 tb/tb_fadd2_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fadd2_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fadd2_seq_pkg
//  Description : Shared definitions for the fadd2_seq sequential adder.
//                Holds the controller state encoding, derived sizing
//                helpers (slice count, counter width) and the WIDTH
//                legality predicate.
//  Revision    : 1.0  initial release
// ============================================================================
package fadd2_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Number of 2-bit slices needed to cover a w-bit operand.
   function automatic int nslices(input int w);
      return w / 2;
   endfunction

   // Slice counter width: clog2(N), but never narrower than one bit.
   function automatic int cnt_width(input int w);
      int n;
      n = w / 2;
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Operands are consumed two bits at a time, so WIDTH must be even.
   function automatic bit width_ok(input int w);
      return (w >= 2) && ((w % 2) == 0);
   endfunction

endpackage : fadd2_seq_pkg
`default_nettype wire

// File: rtl/fadd2_slice.sv
`default_nettype none
// ============================================================================
//  Module      : fadd2_slice
//  Description : Combinational 2-bit full-add slice. Bit 0 carry feeds
//                bit 1; both per-bit carries are exposed so the caller can
//                derive two's-complement overflow on the top slice.
//  Ports       : A0,A1,B0,B1  operand bits (bit 0 / bit 1)
//                CI           carry into bit 0
//                S0,S1        sum bits
//                CO0,CO1      carry out of bit 0 / bit 1
//  Revision    : 1.0  initial release
// ============================================================================
module fadd2_slice (
   input  logic A0,
   input  logic A1,
   input  logic B0,
   input  logic B1,
   input  logic CI,
   output logic S0,
   output logic S1,
   output logic CO0,
   output logic CO1
);

   assign S0  = A0 ^ B0 ^ CI;
   assign CO0 = (A0 & B0) | (A0 & CI) | (B0 & CI);
   assign S1  = A1 ^ B1 ^ CO0;
   assign CO1 = (A1 & B1) | (A1 & CO0) | (B1 & CO0);

endmodule : fadd2_slice
`default_nettype wire

// File: rtl/fadd2_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fadd2_seq
//  Description : Sequential ripple adder. Computes A+B+CI two bits per clock
//                through a single fadd2_slice, with the inter-slice carry
//                held in a flop. Start/done handshake, all outputs registered.
//  Ports       : CK     clock, rising edge
//                CD     synchronous active-high reset
//                START  request (honoured in IDLE and on the DONE cycle)
//                A, B   WIDTH-bit operands, captured on accepted START
//                CI     carry-in, captured on accepted START
//                BUSY   slices being processed
//                DONE   one-cycle completion pulse
//                S      sum, COUT carry out, V two's-complement overflow
//  Revision    : 1.0  initial release
// ============================================================================
module fadd2_seq
   import fadd2_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             CK,
   input  logic             CD,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CI,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] S,
   output logic             COUT,
   output logic             V
);

   localparam int              c_N    = nslices(WIDTH);
   localparam int              c_CW   = cnt_width(WIDTH);
   localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);

   generate
      if (!width_ok(WIDTH)) begin : g_bad_width
         $error("fadd2_seq: WIDTH must be even and >= 2");
      end
   endgenerate

   state_t            r_state;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [WIDTH-1:0]  r_sum;
   logic              r_carry;
   logic [c_CW-1:0]   r_cnt;
   logic              r_busy;
   logic              r_done;
   logic [WIDTH-1:0]  r_s;
   logic              r_cout;
   logic              r_v;

   logic              w_s0;
   logic              w_s1;
   logic              w_co0;
   logic              w_co1;
   logic [WIDTH-1:0]  w_sum_next;

   fadd2_slice u_slice (
      .A0  (r_a[0]),
      .A1  (r_a[1]),
      .B0  (r_b[0]),
      .B1  (r_b[1]),
      .CI  (r_carry),
      .S0  (w_s0),
      .S1  (w_s1),
      .CO0 (w_co0),
      .CO1 (w_co1)
   );

   // New slice result enters at the top; after N shifts the low slice
   // has reached bit 0 and the register holds the complete sum.
   generate
      if (WIDTH == 2) begin : g_sum_w2
         assign w_sum_next = {w_s1, w_s0};
      end else begin : g_sum_wide
         assign w_sum_next = {w_s1, w_s0, r_sum[WIDTH-1:2]};
      end
   endgenerate

   always_ff @(posedge CK) begin
      if (CD) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_s     <= '0;
         r_cout  <= 1'b0;
         r_v     <= 1'b0;
      end else begin
         case (r_state)
            // DONE accepts START exactly like IDLE so back-to-back
            // operations run without an idle bubble.
            ST_IDLE, ST_DONE: begin
               r_done <= 1'b0;
               if (START) begin
                  r_a     <= A;
                  r_b     <= B;
                  r_carry <= CI;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               r_a     <= r_a >> 2;
               r_b     <= r_b >> 2;
               r_sum   <= w_sum_next;
               r_carry <= w_co1;
               r_cnt   <= r_cnt + c_CW'(1);
               if (r_cnt == c_LAST) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_s     <= w_sum_next;
                  r_cout  <= w_co1;
                  // CO0 of the top slice is the carry into the MSB.
                  r_v     <= w_co0 ^ w_co1;
                  r_state <= ST_DONE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign BUSY = r_busy;
   assign DONE = r_done;
   assign S    = r_s;
   assign COUT = r_cout;
   assign V    = r_v;

endmodule : fadd2_seq
`default_nettype wire

// File: tb/tb_fadd2_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fadd2_seq
//  Description : Directed self-checking bench for fadd2_seq (WIDTH=8 and
//                WIDTH=2 instances sharing clock and reset).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fadd2_seq;

   logic       CK = 1'b0;
   logic       CD = 1'b1;

   logic       START = 1'b0;
   logic [7:0] A = '0;
   logic [7:0] B = '0;
   logic       CI = 1'b0;
   logic       BUSY;
   logic       DONE;
   logic [7:0] S;
   logic       COUT;
   logic       V;

   logic       START2 = 1'b0;
   logic [1:0] A2 = '0;
   logic [1:0] B2 = '0;
   logic       CI2 = 1'b0;
   logic       BUSY2;
   logic       DONE2;
   logic [1:0] S2;
   logic       COUT2;
   logic       V2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CK = ~CK;

   fadd2_seq #(.WIDTH(8)) u_dut8 (
      .CK(CK), .CD(CD), .START(START), .A(A), .B(B), .CI(CI),
      .BUSY(BUSY), .DONE(DONE), .S(S), .COUT(COUT), .V(V)
   );

   fadd2_seq #(.WIDTH(2)) u_dut2 (
      .CK(CK), .CD(CD), .START(START2), .A(A2), .B(B2), .CI(CI2),
      .BUSY(BUSY2), .DONE(DONE2), .S(S2), .COUT(COUT2), .V(V2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One WIDTH=8 operation from idle: START for one cycle, BUSY for 4
   // cycles, then the DONE pulse carrying the results, then DONE low.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input logic [7:0] es, input logic ec, input logic ev);
      @(negedge CK);
      START = 1'b1; A = a; B = b; CI = ci;
      @(negedge CK);
      START = 1'b0; A = 8'hEE; B = 8'hDD; CI = 1'b1;
      for (int j = 0; j < 4; j++) begin
         check("busy", BUSY, 1);
         check("no_done_in_run", DONE, 0);
         @(negedge CK);
      end
      check("done", DONE, 1);
      check("busy_at_done", BUSY, 0);
      check("sum", S, es);
      check("cout", COUT, ec);
      check("ovf", V, ev);
      @(negedge CK);
      check("done_one_cycle", DONE, 0);
   endtask

   typedef struct {
      logic [7:0] a, b;
      logic       ci;
      logic [7:0] s;
      logic       c, v;
   } vec_t;

   vec_t stream[4];

   initial begin
      logic [7:0] prev_s;
      logic [2:0] tot;
      logic       cin1;

      stream[0] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
      stream[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      stream[2] = '{8'hC0, 8'hC0, 1'b1, 8'h81, 1'b1, 1'b0};
      stream[3] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};

      // Reset state
      repeat (2) @(posedge CK);
      @(negedge CK);
      check("rst_busy", BUSY, 0);
      check("rst_done", DONE, 0);
      check("rst_s", S, 0);
      check("rst_cout", COUT, 0);
      check("rst_v", V, 0);
      check("rst_busy2", BUSY2, 0);
      check("rst_s2", S2, 0);
      CD = 1'b0;

      // Basic operations
      op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
      op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      op8(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);

      // START during RUN is ignored
      @(negedge CK);
      START = 1'b1; A = 8'h22; B = 8'h22; CI = 1'b0;
      @(negedge CK);
      START = 1'b0;
      @(negedge CK);
      START = 1'b1; A = 8'h11; B = 8'h11;
      @(negedge CK);
      START = 1'b0;
      @(negedge CK);
      @(negedge CK);
      check("ign_done", DONE, 1);
      check("ign_sum", S, 8'h44);
      for (int j = 0; j < 6; j++) begin
         @(negedge CK);
         check("ign_no_2nd_done", DONE, 0);
         check("ign_idle", BUSY, 0);
      end

      // Reset in the middle of RUN
      @(negedge CK);
      START = 1'b1; A = 8'h77; B = 8'h11; CI = 1'b0;
      @(negedge CK);
      START = 1'b0;
      @(negedge CK);
      CD = 1'b1;
      @(negedge CK);
      check("mid_rst_busy", BUSY, 0);
      check("mid_rst_done", DONE, 0);
      check("mid_rst_s", S, 0);
      check("mid_rst_cout", COUT, 0);
      check("mid_rst_v", V, 0);
      CD = 1'b0;
      for (int j = 0; j < 5; j++) begin
         @(negedge CK);
         check("mid_rst_no_done", DONE, 0);
      end
      op8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

      // START held high: back-to-back ops, DONE every 5 cycles
      prev_s = 8'h03;
      @(negedge CK);
      START = 1'b1; A = stream[0].a; B = stream[0].b; CI = stream[0].ci;
      @(negedge CK);
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 4; j++) begin
            check("strm_busy", BUSY, 1);
            check("strm_no_done", DONE, 0);
            check("strm_s_hold", S, prev_s);
            A = 8'($urandom); B = 8'($urandom); CI = 1'($urandom);
            @(negedge CK);
         end
         check("strm_done", DONE, 1);
         check("strm_sum", S, stream[k].s);
         check("strm_cout", COUT, stream[k].c);
         check("strm_ovf", V, stream[k].v);
         prev_s = stream[k].s;
         if (k < 3) begin
            A = stream[k+1].a; B = stream[k+1].b; CI = stream[k+1].ci;
         end else begin
            START = 1'b0;
         end
         @(negedge CK);
      end
      check("strm_end_idle", BUSY, 0);

      // WIDTH=2: exhaustive against a small arithmetic model
      for (int i = 0; i < 32; i++) begin
         @(negedge CK);
         START2 = 1'b1; A2 = 2'(i >> 3); B2 = 2'(i >> 1); CI2 = 1'(i);
         tot  = 3'(A2) + 3'(B2) + 3'(CI2);
         cin1 = ((A2[0] + B2[0] + CI2) > 1) ? 1'b1 : 1'b0;
         @(negedge CK);
         START2 = 1'b0;
         check("w2_busy", BUSY2, 1);
         check("w2_no_done", DONE2, 0);
         @(negedge CK);
         check("w2_done", DONE2, 1);
         check("w2_sum", S2, tot[1:0]);
         check("w2_cout", COUT2, tot[2]);
         check("w2_ovf", V2, cin1 ^ tot[2]);
      end

      @(negedge CK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // BUSY and DONE must never be high together.
   always @(negedge CK) begin
      if (!CD && BUSY && DONE) begin
         n_fail++;
         $display("FAIL busy_done_overlap: got BUSY=1 DONE=1 expected not both");
      end
   end

endmodule : tb_fadd2_seq
`default_nettype wire
